// File: rtl/xpmwrap_pkg.sv
// Shared types for the port-B burst reader: FSM states and the sideband
// carried with every returned word.
package xpmwrap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Sideband captured alongside each read word; the data field is attached
    // in the reader, where the RAM data width is known.
    typedef struct packed {
        logic dbiterr;
        logic sbiterr;
        logic last;
    } rd_side_t;

endpackage

// File: rtl/xpmwrap_sync_fifo.sv
// Register-based synchronous FIFO with occupancy count. Storage is not reset;
// pointers and count are, so contents are only meaningful while non-empty.
module xpmwrap_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int             PTR_W  = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_V = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FULL_V) || do_pop);

    // Storage write; data registers carry no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/xpmwrap_sdpram_burst_reader.sv
// Port-B burst read engine: turns an (addr, len) command into sequential RAM
// reads, tracks the fixed read latency and returns words as a valid/ready
// stream with last and ECC sideband. Issue is credit-limited so the return
// FIFO can never overflow under backpressure.
module xpmwrap_sdpram_burst_reader
    import xpmwrap_pkg::*;
#(
    parameter int ADDR_WIDTH_B      = 6,
    parameter int READ_DATA_WIDTH_B = 32,
    parameter int READ_LATENCY_B    = 2,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         clkb,
    input  logic                         rstb,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ADDR_WIDTH_B-1:0]      cmd_addr,
    input  logic [ADDR_WIDTH_B:0]        cmd_len,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [READ_DATA_WIDTH_B-1:0] m_tdata,
    output logic                         m_tlast,
    output logic [1:0]                   m_tuser,
    output logic                         busy,
    output logic                         ram_enb,
    output logic [ADDR_WIDTH_B-1:0]      ram_addrb,
    output logic                         ram_regceb,
    input  logic [READ_DATA_WIDTH_B-1:0] ram_doutb,
    input  logic                         ram_sbiterrb,
    input  logic                         ram_dbiterrb
);
    localparam int                    CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]        DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH_B:0] LEN_ONE = (ADDR_WIDTH_B+1)'(1);

    typedef struct packed {
        rd_side_t                     side;
        logic [READ_DATA_WIDTH_B-1:0] data;
    } rd_entry_t;
    localparam int ENTRY_W = $bits(rd_entry_t);

    state_t                    state_q, state_d;
    logic                      run_q;
    logic [ADDR_WIDTH_B-1:0]   addr_q;
    logic [ADDR_WIDTH_B:0]     remaining_q;
    logic [READ_LATENCY_B-1:0] vld_p, last_p;
    logic                      cmd_take, issue, credit_ok, pop, push, fifo_empty;
    logic [CNT_W-1:0]          inflight, fifo_count;
    logic [ENTRY_W-1:0]        push_bits, head_bits;
    rd_entry_t                 head;

    function automatic logic [CNT_W-1:0] count_ones(input logic [READ_LATENCY_B-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < READ_LATENCY_B; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    // A read may issue only if every outstanding read plus every buffered
    // word still leaves a free FIFO slot for it.
    assign inflight  = count_ones(vld_p);
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_V;
    assign pop       = m_tvalid && m_tready;
    assign head      = rd_entry_t'(head_bits);

    // Next-state and command/issue decode.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        cmd_take  = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = run_q;
                if (cmd_valid && run_q && (cmd_len != '0)) begin
                    cmd_take = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                issue = credit_ok;
                if (credit_ok && (remaining_q == LEN_ONE)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && head.side.last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; run_q marks the first edge after reset release.
    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Burst address and remaining-word counters.
    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if (cmd_take) begin
            addr_q      <= cmd_addr;
            remaining_q <= cmd_len;
        end else if (issue) begin
            addr_q      <= addr_q + ADDR_WIDTH_B'(1);
            remaining_q <= remaining_q - LEN_ONE;
        end
    end

    // Latency pipe: stage p0 is the issue edge, the last stage lines up with doutb.
    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p[0]  <= issue;
            last_p[0] <= issue && (remaining_q == LEN_ONE);
            for (int i = 1; i < READ_LATENCY_B; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
            end
        end
    end

    assign push      = vld_p[READ_LATENCY_B-1];
    assign push_bits = {ram_dbiterrb, ram_sbiterrb, last_p[READ_LATENCY_B-1], ram_doutb};

    xpmwrap_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .clk   (clkb),
        .rst   (rstb),
        .push  (push),
        .din   (push_bits),
        .pop   (pop),
        .dout  (head_bits),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head fields are masked while empty so the stream reads zero after reset.
    assign m_tvalid   = !fifo_empty;
    assign m_tdata    = m_tvalid ? head.data : '0;
    assign m_tlast    = m_tvalid && head.side.last;
    assign m_tuser    = m_tvalid ? {head.side.dbiterr, head.side.sbiterr} : 2'b00;
    assign busy       = (state_q != IDLE);
    assign ram_enb    = issue;
    assign ram_addrb  = addr_q;
    assign ram_regceb = run_q;

endmodule

// File: tb/tb_xpmwrap_sdpram_burst_reader.sv
// Directed bench for the port-B burst reader with a latency-2 RAM model and a
// scoreboard of expected beats built from the bench's own memory image.
module tb_xpmwrap_sdpram_burst_reader;

    logic        clk = 1'b0;
    logic        rstb;
    logic        cmd_valid, cmd_ready;
    logic [5:0]  cmd_addr;
    logic [6:0]  cmd_len;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [1:0]  m_tuser;
    logic        busy, ram_enb, ram_regceb;
    logic [5:0]  ram_addrb;
    logic [31:0] ram_doutb;
    logic        ram_sbiterrb, ram_dbiterrb;

    xpmwrap_sdpram_burst_reader dut (
        .clkb(clk), .rstb(rstb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .busy(busy), .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_regceb(ram_regceb),
        .ram_doutb(ram_doutb), .ram_sbiterrb(ram_sbiterrb), .ram_dbiterrb(ram_dbiterrb)
    );

    always #5 clk = ~clk;

    // RAM model, read latency 2: enb sampled, then output register gated by regceb.
    logic [31:0] mem [64];
    logic        sflag [64];
    logic        dflag [64];
    logic [31:0] r0_d;
    logic        r0_s, r0_db;
    always @(posedge clk) begin
        if (ram_enb) begin
            r0_d  <= mem[ram_addrb];
            r0_s  <= sflag[ram_addrb];
            r0_db <= dflag[ram_addrb];
        end
        if (ram_regceb) begin
            ram_doutb    <= r0_d;
            ram_sbiterrb <= r0_s;
            ram_dbiterrb <= r0_db;
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  user;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int   tests = 0, fails = 0;
    int   cyc = 0, cmd_c = 0, prev_last = 0, c1 = 0;
    int   first_enb, last_enb, first_vld, last_cyc, idle_cyc, enb_cnt, beats, occ = 0;
    logic acc, any_busy, any_vld, stall_prev = 1'b0;
    logic [31:0] hold_data;
    logic [3:0]  pat = 4'b1001;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (cmd_valid && cmd_ready) acc = 1'b1;
        if (busy) any_busy = 1'b1;
        if (m_tvalid) any_vld = 1'b1;
        if (m_tvalid && first_vld < 0) first_vld = cyc;
        if (!busy && idle_cyc < 0) idle_cyc = cyc;
        if (stall_prev) chk("hold_tdata", 64'(m_tdata), 64'(hold_data));
        if (ram_enb) begin
            tests++;
            assert (occ < 4) else begin
                fails++;
                $error("FAIL credit: occupancy %0d when ram_enb high, limit 4", occ);
            end
            occ++;
            enb_cnt++;
            if (first_enb < 0) first_enb = cyc;
            last_enb = cyc;
        end
        if (m_tvalid && m_tready) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_beat: got 0x%0h, expected no beat", m_tdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("tdata", 64'(m_tdata), 64'(e.data));
                chk("tlast", 64'(m_tlast), 64'(e.last));
                chk("tuser", 64'(m_tuser), 64'(e.user));
            end
            if (m_tlast) last_cyc = cyc;
            beats++;
            occ--;
        end
        stall_prev = m_tvalid && !m_tready;
        hold_data  = m_tdata;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [5:0] a, input logic [6:0] n);
        logic [5:0] a2;
        int w;
        w = 0;
        cmd_addr  = a;
        cmd_len   = n;
        cmd_valid = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            a2 = a + 6'(i);
            sb.push_back('{data: mem[a2], last: (i == int'(n) - 1), user: {dflag[a2], sflag[a2]}});
        end
        acc = 1'b0;
        while (!acc && w < 200) begin
            tick();
            w++;
        end
        tests++;
        assert (acc) else begin
            fails++;
            $error("FAIL cmd_accept: not accepted within 200 cycles, expected accept");
        end
        cmd_valid = 1'b0;
        prev_last = last_cyc;
        cmd_c     = cyc;
        first_enb = -1; last_enb = -1; first_vld = -1; last_cyc = -1; idle_cyc = -1;
        enb_cnt = 0; beats = 0; any_busy = 1'b0; any_vld = 1'b0;
    endtask

    task automatic run(input bit bp, input int budget);
        int w;
        w = 0;
        while (!(sb.size() == 0 && idle_cyc >= 0) && w < budget) begin
            m_tready = bp ? pat[cyc[1:0]] : 1'b1;
            tick();
            w++;
        end
        tests++;
        assert (sb.size() == 0 && idle_cyc >= 0) else begin
            fails++;
            $error("FAIL run_timeout: %0d beats outstanding, busy %0b, expected 0 and idle", sb.size(), busy);
        end
        m_tready = 1'b1;
    endtask

    task automatic check_zero(input string p);
        chk({p, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        chk({p, "_tvalid"},    64'(m_tvalid),  64'(0));
        chk({p, "_tdata"},     64'(m_tdata),   64'(0));
        chk({p, "_tlast"},     64'(m_tlast),   64'(0));
        chk({p, "_tuser"},     64'(m_tuser),   64'(0));
        chk({p, "_busy"},      64'(busy),      64'(0));
        chk({p, "_enb"},       64'(ram_enb),   64'(0));
        chk({p, "_addrb"},     64'(ram_addrb), 64'(0));
        chk({p, "_regceb"},    64'(ram_regceb),64'(0));
    endtask

    initial begin
        rstb = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_tready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem[i]   = {8'h5A, 2'b00, 6'(i), 16'h1000 + 16'(i * 37)};
            sflag[i] = 1'b0;
            dflag[i] = 1'b0;
        end
        mem[5] = 32'hA5A5_0001;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        @(posedge clk); #1;
        rstb = 1'b0;
        tick();
        chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));
        chk("regceb_after_rst", 64'(ram_regceb), 64'(1));

        // Single word
        send(6'd5, 7'd1);
        run(1'b0, 50);
        chk("single_first_enb", 64'(first_enb), 64'(cmd_c));
        chk("single_first_vld", 64'(first_vld), 64'(cmd_c + 3));
        chk("single_last", 64'(last_cyc), 64'(cmd_c + 3));
        chk("single_busy_drop", 64'(idle_cyc), 64'(cmd_c + 4));
        chk("single_enb_cnt", 64'(enb_cnt), 64'(1));

        // 8-word burst, full throughput
        send(6'h10, 7'd8);
        run(1'b0, 50);
        chk("b8_first_enb", 64'(first_enb), 64'(cmd_c));
        chk("b8_last_enb", 64'(last_enb), 64'(cmd_c + 7));
        chk("b8_enb_cnt", 64'(enb_cnt), 64'(8));
        chk("b8_first_vld", 64'(first_vld), 64'(cmd_c + 3));
        chk("b8_last", 64'(last_cyc), 64'(cmd_c + 10));

        // Backpressure 1-0-0-1
        send(6'h20, 7'd16);
        run(1'b1, 200);
        chk("bp_beats", 64'(beats), 64'(16));
        chk("bp_enb_cnt", 64'(enb_cnt), 64'(16));

        // Address wrap
        send(6'd62, 7'd4);
        run(1'b0, 50);
        chk("wrap_beats", 64'(beats), 64'(4));

        // Zero-length command
        send(6'd9, 7'd0);
        repeat (8) tick();
        chk("len0_busy", 64'(any_busy), 64'(0));
        chk("len0_tvalid", 64'(any_vld), 64'(0));
        chk("len0_cmd_ready", 64'(cmd_ready), 64'(1));

        // Full-memory burst, next command back to back
        send(6'd0, 7'd64);
        c1 = cmd_c;
        send(6'd3, 7'd1);
        chk("b64_last", 64'(prev_last), 64'(c1 + 66));
        chk("b64_next_accept", 64'(cmd_c), 64'(prev_last + 2));
        run(1'b0, 50);

        // Reset during beat 3
        send(6'h08, 7'd8);
        begin
            int w;
            w = 0;
            while (beats < 2 && w < 100) begin tick(); w++; end
        end
        chk("beat3_present", 64'(m_tvalid), 64'(1));
        rstb = 1'b1;
        sb.delete();
        occ = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk); #1;
        rstb = 1'b0;
        any_vld = 1'b0;
        repeat (12) tick();
        chk("no_stale_beats", 64'(any_vld), 64'(0));
        send(6'h30, 7'd3);
        run(1'b0, 50);
        chk("fresh_first_vld", 64'(first_vld), 64'(cmd_c + 3));
        chk("fresh_beats", 64'(beats), 64'(3));

        // ECC sideband: sbiterr on word 2, dbiterr on word 4
        sflag[6'h29] = 1'b1;
        dflag[6'h2B] = 1'b1;
        send(6'h28, 7'd4);
        run(1'b0, 50);
        sflag[6'h29] = 1'b0;
        dflag[6'h2B] = 1'b0;
        chk("ecc_beats", 64'(beats), 64'(4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
